// File: rtl/coll_pkg.sv
// Shared definitions for the pairwise collision-detection scan logic:
// object record layout, scan FSM state encoding and datapath widths
// (also used by the detector wrapper).
package coll_pkg;

  localparam int COORD_W = 16;
  localparam int RSQ_W   = 32;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] vx;
    logic [COORD_W-1:0] vy;
  } coll_obj_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_REPORT = 3'd3,
    ST_DONE   = 3'd4
  } coll_state_e;

  // Number of unordered pairs (i<j) among n objects.
  function automatic int pair_total(input int n);
    return n * (n - 1) / 2;
  endfunction

endpackage

// File: rtl/coll_pair_iter.sv
// Upper-triangle (i<j) index generator. init restarts at (0,1); advance
// steps to the next pair in row-major order. last flags (N_OBJ-2, N_OBJ-1);
// advancing past it holds the final pair.
module coll_pair_iter #(
  parameter  int N_OBJ = 8,
  localparam int IDX_W = $clog2(N_OBJ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             advance,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic             last
);

  localparam logic [IDX_W-1:0] ONE    = IDX_W'(1);
  localparam logic [IDX_W-1:0] TWO    = IDX_W'(2);
  localparam logic [IDX_W-1:0] I_LAST = IDX_W'(N_OBJ - 2);
  localparam logic [IDX_W-1:0] J_LAST = IDX_W'(N_OBJ - 1);

  assign last = (i == I_LAST) && (j == J_LAST);

  // Step j along the row; at row end move to the next row, starting just right of the diagonal.
  always_ff @(posedge clk) begin
    if (rst || init) begin
      i <= '0;
      j <= ONE;
    end else if (advance && !last) begin
      if (j != J_LAST) begin
        j <= j + ONE;
      end else begin
        i <= i + ONE;
        j <= i + TWO;
      end
    end
  end

endmodule

// File: rtl/coll_pair_sched.sv
// Scan controller for the shared pairwise collision detector.
// Holds an N_OBJ object table, walks every pair (i<j) through an external
// detector, reports each colliding pair downstream and pulses done with the
// hit count.
// Build option: define COLL_FIRST_HIT_EN to end the scan right after the
// first reported hit has been accepted.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. valid, once raised, stays high with its payload unchanged until
// that transfer; ready may toggle freely and never depends on valid here.
// det_rsp_valid is a one-cycle strobe with no ready; it only counts while
// the FSM is waiting for a response.
module coll_pair_sched
  import coll_pkg::*;
#(
  parameter  int N_OBJ  = 8,
  localparam int IDX_W  = $clog2(N_OBJ),
  localparam int PCNT_W = $clog2(N_OBJ * (N_OBJ - 1) / 2 + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic [COORD_W-1:0] wr_vx,
  input  logic [COORD_W-1:0] wr_vy,
  input  logic [RSQ_W-1:0]   radius_sq,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [PCNT_W-1:0]  hit_count,
  output logic               det_req_valid,
  input  logic               det_req_ready,
  output logic [COORD_W-1:0] det_x1,
  output logic [COORD_W-1:0] det_y1,
  output logic [COORD_W-1:0] det_vx1,
  output logic [COORD_W-1:0] det_vy1,
  output logic [COORD_W-1:0] det_x2,
  output logic [COORD_W-1:0] det_y2,
  output logic [COORD_W-1:0] det_vx2,
  output logic [COORD_W-1:0] det_vy2,
  output logic [RSQ_W-1:0]   det_r,
  input  logic               det_rsp_valid,
  input  logic               det_rsp_hit,
  output logic               hit_valid,
  input  logic               hit_ready,
  output logic [IDX_W-1:0]   hit_i,
  output logic [IDX_W-1:0]   hit_j,
  output logic [2:0]         state_dbg
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_ISSUE  = ST_ISSUE;
  localparam logic [2:0] S_WAIT   = ST_WAIT;
  localparam logic [2:0] S_REPORT = ST_REPORT;
  localparam logic [2:0] S_DONE   = ST_DONE;

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [RSQ_W-1:0]  r_q;
  logic              iter_init;
  logic              iter_adv;
  logic [IDX_W-1:0]  pi;
  logic [IDX_W-1:0]  pj;
  logic              pair_last;
  coll_obj_t         tbl [N_OBJ];
  coll_obj_t         obj_i;
  coll_obj_t         obj_j;

  coll_pair_iter #(.N_OBJ(N_OBJ)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .init    (iter_init),
    .advance (iter_adv),
    .i       (pi),
    .j       (pj),
    .last    (pair_last)
  );

  // Object table: writable only while no scan is running, so operands stay frozen mid-scan.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      tbl[wr_idx] <= '{x: wr_x, y: wr_y, vx: wr_vx, vy: wr_vy};
    end
  end

  // Next-state and pair-iterator control.
  always_comb begin
    state_d   = state_q;
    iter_init = 1'b0;
    iter_adv  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ISSUE;
          iter_init = 1'b1;
        end
      end
      S_ISSUE: begin
        if (det_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (det_rsp_valid) begin
          if (det_rsp_hit) begin
            state_d = S_REPORT;
          end else if (pair_last) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_ISSUE;
            iter_adv = 1'b1;
          end
        end
      end
      S_REPORT: begin
        if (hit_ready) begin
`ifdef COLL_FIRST_HIT_EN
          state_d = S_DONE;
`else
          if (pair_last) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_ISSUE;
            iter_adv = 1'b1;
          end
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register, radius latch at start, and hit counter (cleared at start, held after done).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      r_q       <= '0;
      hit_count <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        r_q       <= radius_sq;
        hit_count <= '0;
      end else if (state_q == S_WAIT && det_rsp_valid && det_rsp_hit) begin
        hit_count <= hit_count + PCNT_W'(1);
      end
    end
  end

  assign obj_i = tbl[pi];
  assign obj_j = tbl[pj];

  assign busy          = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_REPORT);
  assign done          = (state_q == S_DONE);
  assign det_req_valid = (state_q == S_ISSUE);
  assign hit_valid     = (state_q == S_REPORT);
  assign hit_i         = hit_valid ? pi : '0;
  assign hit_j         = hit_valid ? pj : '0;
  assign state_dbg     = state_q;

  assign det_x1  = obj_i.x;
  assign det_y1  = obj_i.y;
  assign det_vx1 = obj_i.vx;
  assign det_vy1 = obj_i.vy;
  assign det_x2  = obj_j.x;
  assign det_y2  = obj_j.y;
  assign det_vx2 = obj_j.vx;
  assign det_vy2 = obj_j.vy;
  assign det_r   = r_q;

endmodule

// File: tb/tb_coll_pair_sched.sv
// Bench for coll_pair_sched with N_OBJ=4. A reference model enumerates the
// expected pair sequence, hits and final count per scan into queues; a
// negedge monitor compares every presented request, hit and done against
// them. Define COLL_FIRST_HIT_EN for both bench and RTL to cover early exit.
module tb_coll_pair_sched;
  import coll_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [15:0]   wr_x, wr_y, wr_vx, wr_vy;
  logic [31:0]   radius_sq;
  logic          start;
  logic          busy, done;
  logic [PW-1:0] hit_count;
  logic          det_req_valid, det_req_ready;
  logic [15:0]   det_x1, det_y1, det_vx1, det_vy1, det_x2, det_y2, det_vx2, det_vy2;
  logic [31:0]   det_r;
  logic          det_rsp_valid, det_rsp_hit;
  logic          hit_valid, hit_ready;
  logic [IW-1:0] hit_i, hit_j;
  logic [2:0]    state_dbg;

  // Clock and DUT
  always #5 clk = ~clk;

  coll_pair_sched #(.N_OBJ(N)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_x(wr_x), .wr_y(wr_y), .wr_vx(wr_vx), .wr_vy(wr_vy),
    .radius_sq(radius_sq), .start(start), .busy(busy), .done(done),
    .hit_count(hit_count), .det_req_valid(det_req_valid), .det_req_ready(det_req_ready),
    .det_x1(det_x1), .det_y1(det_y1), .det_vx1(det_vx1), .det_vy1(det_vy1),
    .det_x2(det_x2), .det_y2(det_y2), .det_vx2(det_vx2), .det_vy2(det_vy2),
    .det_r(det_r), .det_rsp_valid(det_rsp_valid), .det_rsp_hit(det_rsp_hit),
    .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_i(hit_i), .hit_j(hit_j),
    .state_dbg(state_dbg)
  );

  // Bench state: reference table, scoreboard queues, stimulus knobs
  int checks = 0;
  int errors = 0;
  logic [15:0]     tb_x [N];
  logic [15:0]     tb_y [N];
  logic [15:0]     tb_vx[N];
  logic [15:0]     tb_vy[N];
  bit              hit_mask[N][N];
  logic [31:0]     exp_r;
  logic [2*IW-1:0] req_q[$];
  logic [2*IW-1:0] hit_q[$];
  logic [PW-1:0]   done_q[$];
  int   done_seen = 0;
  int   acc_seen  = 0;
  time  done_t    = 0;
  int   ready_pct = 100, hready_pct = 100, rsp_min = 0, rsp_max = 0;
  int   req_stall_i = -1, req_stall_j = -1, req_stall_n = 0, hit_stall_n = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [15:0] x);
    for (int k = 0; k < N; k++) if (tb_x[k] === x) return k;
    return -1;
  endfunction

  function automatic logic [15:0] new_x();
    logic [15:0] x;
    x = 16'($urandom_range(0, 16'h7FFF));
    while (idx_of(x) >= 0) x = 16'($urandom_range(0, 16'h7FFF));
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: write one table slot while idle and mirror it in the reference table
  task automatic write_obj(input int k, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] vx, input logic [15:0] vy);
    wr_en = 1'b1; wr_idx = IW'(k); wr_x = x; wr_y = y; wr_vx = vx; wr_vy = vy;
    tb_x[k] = x; tb_y[k] = y; tb_vx[k] = vx; tb_vy[k] = vy;
    tick();
    wr_en = 1'b0;
  endtask

  // Reference model: the ordered pair list, the reported hits and the final count
  task automatic push_expect(output int exp_hits);
    bit stop;
    stop = 1'b0;
    exp_hits = 0;
    for (int a = 0; a < N - 1 && !stop; a++) begin
      for (int b = a + 1; b < N && !stop; b++) begin
        req_q.push_back({IW'(a), IW'(b)});
        if (hit_mask[a][b]) begin
          hit_q.push_back({IW'(a), IW'(b)});
          exp_hits++;
`ifdef COLL_FIRST_HIT_EN
          stop = 1'b1;
`endif
        end
      end
    end
    done_q.push_back(PW'(exp_hits));
  endtask

  // Driver: one scan. mode 0 plain, 1 start+write mid-scan, 2 write slot 3 with start.
  task automatic run_scan(input string tag, input int mode, input bit check_lat);
    int   exp_hits;
    int   d0;
    time  start_t;
    logic [15:0] nx;
    if (mode == 2) begin
      nx = new_x();
      wr_en = 1'b1; wr_idx = IW'(3); wr_x = nx;
      wr_y = 16'($urandom); wr_vx = 16'($urandom); wr_vy = 16'($urandom);
      tb_x[3] = nx; tb_y[3] = wr_y; tb_vx[3] = wr_vx; tb_vy[3] = wr_vy;
    end
    push_expect(exp_hits);
    exp_r = $urandom;
    radius_sq = exp_r;
    d0 = done_seen;
    start = 1'b1;
    tick();
    start = 1'b0; wr_en = 1'b0;
    start_t = $time - 1;
    radius_sq = $urandom;
    chk({tag, "_busy_started"}, busy, 1'b1);
    if (mode == 1) begin
      repeat (2) tick();
      start = 1'b1; wr_en = 1'b1; wr_idx = '0; wr_x = 16'hBEEF; wr_y = 16'h1234;
      tick();
      start = 1'b0; wr_en = 1'b0;
    end
    for (int k = 0; k < 3000 && done_seen == d0; k++) @(negedge clk);
    if (done_seen == d0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done expected done within 3000 cycles", tag);
    end else if (check_lat) begin
      chk({tag, "_latency"}, 128'(done_t - start_t), 128'(125));
    end
    repeat (3) tick();
    chk({tag, "_req_left"}, req_q.size(), 0);
    chk({tag, "_hit_left"}, hit_q.size(), 0);
    chk({tag, "_busy_after"}, busy, 1'b0);
    chk({tag, "_count_held"}, hit_count, exp_hits);
    req_q.delete(); hit_q.delete(); done_q.delete();
  endtask

  task automatic clear_mask();
    for (int a = 0; a < N; a++) for (int b = 0; b < N; b++) hit_mask[a][b] = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_hit_count"}, hit_count, '0);
    chk({tag, "_req_valid"}, det_req_valid, 1'b0);
    chk({tag, "_hit_valid"}, hit_valid, 1'b0);
    chk({tag, "_hit_ij"}, {hit_i, hit_j}, '0);
    chk({tag, "_state"}, state_dbg, 3'(ST_IDLE));
  endtask

  // Detector and downstream model: accepts requests, answers after a delay, drives ready lines
  initial begin : det_model
    bit pend, pend_hit;
    int pend_dly, a, b;
    pend = 1'b0; pend_hit = 1'b0; pend_dly = 0;
    det_req_ready = 1'b0; det_rsp_valid = 1'b0; det_rsp_hit = 1'b0; hit_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (det_req_valid && det_req_ready && !rst) begin
        a = idx_of(det_x1);
        b = idx_of(det_x2);
        pend     = 1'b1;
        pend_hit = (a >= 0 && b >= 0) ? hit_mask[a][b] : 1'b0;
        pend_dly = $urandom_range(rsp_max, rsp_min);
        acc_seen++;
      end
      @(posedge clk);
      #1;
      det_rsp_valid = 1'b0;
      det_rsp_hit   = 1'($urandom_range(0, 1));
      if (pend) begin
        if (pend_dly == 0) begin
          det_rsp_valid = 1'b1;
          det_rsp_hit   = pend_hit;
          pend          = 1'b0;
        end else begin
          pend_dly--;
        end
      end
      if (det_req_valid && req_stall_n > 0 && idx_of(det_x1) == req_stall_i &&
          idx_of(det_x2) == req_stall_j) begin
        det_req_ready = 1'b0;
        req_stall_n--;
      end else begin
        det_req_ready = ($urandom_range(0, 99) < ready_pct);
      end
      if (hit_valid && hit_stall_n > 0) begin
        hit_ready = 1'b0;
        hit_stall_n--;
      end else begin
        hit_ready = ($urandom_range(0, 99) < hready_pct);
      end
    end
  end

  // Scoreboard monitor: compares each presented request, hit and done with the queues
  initial begin : monitor
    logic [IW-1:0] ei, ej;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (det_req_valid) begin
          if (req_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL req_unexpected: got request x1=%0h x2=%0h expected none", det_x1, det_x2);
          end else begin
            ei = req_q[0][2*IW-1:IW];
            ej = req_q[0][IW-1:0];
            chk("req_operands",
                {det_x1, det_y1, det_vx1, det_vy1, det_x2, det_y2, det_vx2, det_vy2},
                {tb_x[ei], tb_y[ei], tb_vx[ei], tb_vy[ei], tb_x[ej], tb_y[ej], tb_vx[ej], tb_vy[ej]});
            chk("req_radius", det_r, exp_r);
            if (det_req_ready) void'(req_q.pop_front());
          end
        end
        if (hit_valid) begin
          chk("hit_no_req", det_req_valid, 1'b0);
          if (hit_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL hit_unexpected: got hit (%0d,%0d) expected none", hit_i, hit_j);
          end else begin
            chk("hit_pair", {hit_i, hit_j}, hit_q[0]);
            if (hit_ready) void'(hit_q.pop_front());
          end
        end
        if (done) begin
          if (done_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL done_unexpected: got done expected none");
          end else begin
            chk("done_count", hit_count, done_q.pop_front());
          end
          done_t = $time;
          done_seen++;
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test expected finish before 2000000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  // Main sequence
  initial begin
    int d0, a0;
    rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_idx = '0;
    wr_x = '0; wr_y = '0; wr_vx = '0; wr_vy = '0; radius_sq = '0; exp_r = '0;
    for (int k = 0; k < N; k++) begin
      tb_x[k] = 16'hFFF0 + 16'(k); tb_y[k] = '0; tb_vx[k] = '0; tb_vy[k] = '0;
    end
    clear_mask();
    repeat (3) tick();
    check_reset_vals("reset");
    rst = 1'b0;
    for (int k = 0; k < N; k++)
      write_obj(k, new_x(), 16'($urandom), 16'($urandom), 16'($urandom));

    // All misses, immediate handshakes: six requests in order, count 0, minimum latency
    run_scan("all_miss", 0, 1'b1);

    // Single hit on (1,3) with downstream stalled for 5 cycles
    hit_mask[1][3] = 1'b1;
    hit_stall_n = 5;
    run_scan("hit13_stall", 0, 1'b0);
    clear_mask();

    // Slot 2 rewritten, request (0,2) held off by the detector for 3 cycles
    write_obj(2, 16'd100, 16'hFFCE, 16'd3, 16'd0);
    req_stall_i = 0; req_stall_j = 2; req_stall_n = 3;
    run_scan("stall02", 0, 1'b0);
    req_stall_n = 0;

    // start and table write while busy are ignored
    hit_mask[0][3] = 1'b1;
    run_scan("busy_ignore", 1, 1'b0);
    clear_mask();

    // Write and start in the same idle cycle: scan uses the new slot 3
    hit_mask[2][3] = 1'b1;
    run_scan("wr_with_start", 2, 1'b0);
    clear_mask();

    // Reset while waiting on the detector; the late response must be ignored
    for (int a = 0; a < N; a++) for (int b = 0; b < N; b++) hit_mask[a][b] = 1'b1;
    rsp_min = 4; rsp_max = 4;
    begin
      int dummy;
      push_expect(dummy);
    end
    exp_r = $urandom; radius_sq = exp_r;
    a0 = acc_seen;
    d0 = done_seen;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 200 && acc_seen == a0; k++) @(negedge clk);
    if (acc_seen == a0) begin
      checks++; errors++;
      $display("FAIL rst_scan_accept: got no request accepted expected one within 200 cycles");
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_q.delete(); hit_q.delete(); done_q.delete();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check_reset_vals("after_rst");
    end
    chk("rst_no_done", done_seen, d0);
    rsp_min = 0; rsp_max = 0;
    clear_mask();
    run_scan("post_rst_scan", 0, 1'b1);

    // Two hits: early exit after (0,2) when built with first-hit option
    hit_mask[0][2] = 1'b1;
    hit_mask[1][2] = 1'b1;
    run_scan("two_hits", 0, 1'b0);
    clear_mask();

    // Randomized scans: random hit sets, ready lines and response delays
    ready_pct = 60; hready_pct = 50; rsp_min = 0; rsp_max = 3;
    for (int s = 0; s < 6; s++) begin
      for (int a = 0; a < N; a++)
        for (int b = a + 1; b < N; b++) hit_mask[a][b] = ($urandom_range(0, 99) < 35);
      if (s % 2 == 1) write_obj($urandom_range(0, N - 1), new_x(), 16'($urandom), 16'($urandom), 16'($urandom));
      run_scan("random", (s == 3) ? 2 : 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
